// File: rtl/sn76489_bus_writer.sv
// sn76489_bus_writer: buffers PSG command bytes from a valid/ready stream and
// plays each one onto the SN76489 write port (ti_D, ti_nWE, ti_nCE) using the
// chip's READY handshake. It also generates the PSG clock-enable tick.
//
// Handshake: a byte transfers on a CLK100MHZ edge where in_valid && in_ready.
// in_ready depends only on the FIFO fill level and never on in_valid.
module sn76489_bus_writer #(
    parameter int CLK_DIV       = 28,
    parameter int FIFO_DEPTH    = 4,
    parameter int READY_TIMEOUT = 64,
    parameter int GAP_TICKS     = 2
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ti_clk,
    output logic [7:0] ti_D,
    output logic       ti_nWE,
    output logic       ti_nCE,
    input  logic       ti_READY,
    output logic       busy,
    output logic       timeout_err,
    output logic [2:0] state_dbg_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(READY_TIMEOUT + 1);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        STROBE   = 3'd2,
        WAIT_RDY = 3'd3,
        RELEASE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick;
    logic               ti_clk_q;
    logic               rdy_s1_q, rdy_s_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               err_set;
    logic               err_q;
    logic [7:0]         d_q;
    logic               strobe_n_q;

    // Tick divider: div wraps at CLK_DIV-1; tick marks the last cycle of a period.
    assign tick  = (div_q == DIV_W'(CLK_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    // Free-running divider and registered tick pulse.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_q    <= '0;
            ti_clk_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            ti_clk_q <= tick;
        end
    end

    // Double-flop READY into CLK100MHZ; idle level of READY is high.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rdy_s1_q <= 1'b1;
            rdy_s_q  <= 1'b1;
        end else begin
            rdy_s1_q <= ti_READY;
            rdy_s_q  <= rdy_s1_q;
        end
    end

    assign in_ready = (count_q != CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge CLK100MHZ) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // Fill level: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and fill level; pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Write sequencer next state; every transition waits for a tick.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        err_set   = 1'b0;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    to_cnt_d = '0;
                    state_d  = STROBE;
                end
                STROBE: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (to_cnt_d == TO_W'(READY_TIMEOUT)) begin
                        // Chip never answered: drop the byte and move on.
                        err_set   = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = RELEASE;
                    end else if (!rdy_s_q) begin
                        state_d = WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (rdy_s_q) begin
                        gap_cnt_d = '0;
                        state_d   = RELEASE;
                    end else if (to_cnt_d == TO_W'(READY_TIMEOUT)) begin
                        err_set   = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = RELEASE;
                    end
                end
                RELEASE: begin
                    if (gap_cnt_q == GAP_W'(GAP_TICKS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Sequencer state, counters and registered PSG-side outputs.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= IDLE;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            err_q      <= 1'b0;
            d_q        <= 8'h00;
            strobe_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            err_q      <= err_q | err_set;
            if (pop) d_q <= mem_q[rd_ptr_q];
            // Strobes follow the next state so they change with ti_clk.
            strobe_n_q <= !((state_d == STROBE) || (state_d == WAIT_RDY));
        end
    end

    assign ti_clk      = ti_clk_q;
    assign ti_D        = d_q;
    assign ti_nWE      = strobe_n_q;
    assign ti_nCE      = strobe_n_q;
    assign timeout_err = err_q;
    assign busy        = (state_q != IDLE) || (count_q != '0);
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Bench for sn76489_bus_writer: PSG READY model, write monitor with an
// expected-byte queue, and a linear sequence of directed scenarios.
module tb_sn76489_bus_writer;

    localparam int CLK_DIV       = 28;
    localparam int READY_TIMEOUT = 64;
    localparam int GAP_TICKS     = 2;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       ti_clk;
    logic [7:0] ti_D;
    logic       ti_nWE;
    logic       ti_nCE;
    logic       ti_READY;
    logic       busy;
    logic       timeout_err;
    logic [2:0] state_dbg;

    logic [7:0] exp_q [$];
    logic [7:0] exp_b;
    logic [7:0] d_prev_tick;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   tick_n = 0;
    int   writes_seen = 0;
    int   exp_low = 5;
    int   exp_gap = 0;
    int   last_pulse_cyc = -1;
    int   fall_tick = 0;
    int   rise_tick = 0;
    bit   have_rise = 0;
    bit   prev_nwe = 1;
    bit   psg_en = 1;
    int   psg_ph = 0;
    int   psg_low = 0;

    sn76489_bus_writer dut (
        .CLK100MHZ   (clk),
        .CPU_RESETN  (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ti_clk      (ti_clk),
        .ti_D        (ti_D),
        .ti_nWE      (ti_nWE),
        .ti_nCE      (ti_nCE),
        .ti_READY    (ti_READY),
        .busy        (busy),
        .timeout_err (timeout_err),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        #3_000_000;
        n_mis++;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // ---------------- PSG READY model ----------------
    // READY falls one tick after the strobe is first seen, stays low 3 ticks.
    always @(negedge clk) begin
        if (!rst_n || !psg_en) begin
            psg_ph   = 0;
            ti_READY = 1'b1;
        end else if (ti_clk) begin
            case (psg_ph)
                0: if (!ti_nWE) psg_ph = 1;
                1: begin
                    ti_READY = 1'b0;
                    psg_low  = 0;
                    psg_ph   = 2;
                end
                2: begin
                    psg_low++;
                    if (psg_low == 3) begin
                        ti_READY = 1'b1;
                        psg_ph   = 3;
                    end
                end
                default: if (ti_nWE) psg_ph = 0;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_nwe       = 1'b1;
            last_pulse_cyc = -1;
            have_rise      = 1'b0;
        end else begin
            if (ti_clk) begin
                tick_n++;
                if (last_pulse_cyc >= 0) chk("tick_period", cyc - last_pulse_cyc, CLK_DIV);
                last_pulse_cyc = cyc;
            end
            if (prev_nwe && !ti_nWE) begin
                writes_seen++;
                fall_tick = tick_n;
                chk("fall_on_tick", ti_clk, 1);
                chk("nce_low", ti_nCE, 0);
                n_cmp++;
                assert (exp_q.size() != 0) else begin
                    n_mis++;
                    $error("FAIL write_expected: observed write %0h expected none", ti_D);
                end
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    chk("ti_D", ti_D, exp_b);
                    chk("ti_D_setup", d_prev_tick, exp_b);
                end
                if (exp_gap != 0 && have_rise) chk("gap_ticks", tick_n - rise_tick, exp_gap);
            end
            if (!prev_nwe && ti_nWE) begin
                rise_tick = tick_n;
                have_rise = 1'b1;
                chk("low_ticks", tick_n - fall_tick, exp_low);
                chk("rise_on_tick", ti_clk, 1);
                chk("nce_high", ti_nCE, 1);
            end
            if (ti_clk) d_prev_tick = ti_D;
            prev_nwe = ti_nWE;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_tick();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ti_clk && n < 2 * CLK_DIV);
        if (!ti_clk) chk("tick_seen", ti_clk, 1);
    endtask

    task automatic push_byte(input logic [7:0] b, output int waited);
        waited = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("push_accept", in_ready, 1);
        end else begin
            @(posedge clk);
            exp_q.push_back(b);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_fall(input int w0, input int max_ticks);
        int n = 0;
        while (writes_seen == w0 && n < max_ticks * CLK_DIV) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("fall_seen", writes_seen > w0, 1);
    endtask

    task automatic wait_rise(input int max_ticks);
        int n = 0;
        while (!ti_nWE && n < max_ticks * CLK_DIV) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rise_seen", ti_nWE, 1);
    endtask

    task automatic wait_idle(input int max_ticks);
        int n = 0;
        do begin
            wait_tick();
            n++;
        end while (busy && n < max_ticks);
        chk("idle_reached", busy, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int w0;
        int waited;
        logic [7:0] burst [5];

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_nwe", ti_nWE, 1);
        chk("rst_nce", ti_nCE, 1);
        chk("rst_d", ti_D, 8'h00);
        chk("rst_clk", ti_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_state", state_dbg, ST_IDLE);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ti_clk && n < 100);
        chk("first_tick", n, CLK_DIV);
        @(posedge clk);
        #1;
        chk("tick_width", ti_clk, 0);

        // Single write through the PSG model.
        psg_en  = 1'b1;
        exp_low = 5;
        w0 = writes_seen;
        push_byte(8'h8E, waited);
        chk("busy_after_push", busy, 1);
        wait_fall(w0, 10);
        wait_rise(20);
        wait_tick();
        chk("gap1_busy", busy, 1);
        chk("gap1_state", state_dbg, ST_RELEASE);
        wait_tick();
        chk("gap2_busy", busy, 0);
        chk("gap2_state", state_dbg, ST_IDLE);
        chk("d_hold", ti_D, 8'h8E);

        // Timeout: READY held high, then a normal write afterwards.
        psg_en  = 1'b0;
        exp_low = READY_TIMEOUT;
        w0 = writes_seen;
        push_byte(8'h9F, waited);
        wait_fall(w0, 10);
        chk("err_before_to", timeout_err, 0);
        wait_rise(READY_TIMEOUT + 10);
        chk("err_after_to", timeout_err, 1);
        wait_idle(20);
        psg_en  = 1'b1;
        exp_low = 5;
        w0 = writes_seen;
        push_byte(8'hBF, waited);
        wait_idle(30);
        chk("err_sticky", timeout_err, 1);
        chk("to_writes", writes_seen - w0, 1);

        // Burst of five right after a tick with an idle, empty FIFO.
        burst[0] = 8'h8E; burst[1] = 8'h0F; burst[2] = 8'h90;
        burst[3] = 8'h9F; burst[4] = 8'hBF;
        w0 = writes_seen;
        wait_tick();
        for (int i = 0; i < 4; i++) push_byte(burst[i], waited);
        chk("burst_full", in_ready, 0);
        push_byte(burst[4], waited);
        chk("burst_holdoff", waited, CLK_DIV - 4);
        wait_fall(w0, 10);
        exp_gap = GAP_TICKS + 2;
        wait_idle(80);
        exp_gap = 0;
        chk("burst_writes", writes_seen - w0, 5);
        chk("burst_drained", exp_q.size(), 0);

        // Reset while the strobe is low.
        w0 = writes_seen;
        for (int i = 0; i < 3; i++) push_byte(8'h80 + 8'(i), waited);
        wait_fall(w0, 10);
        chk("mid_strobe_low", ti_nWE, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_nwe", ti_nWE, 1);
        chk("async_nce", ti_nCE, 1);
        chk("async_busy", busy, 0);
        chk("async_in_ready", in_ready, 1);
        chk("async_err", timeout_err, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = writes_seen;
        repeat (10) wait_tick();
        chk("flushed_no_write", writes_seen - w0, 0);
        chk("flushed_idle", busy, 0);

        // Wrap-around: ten random bytes through the four-entry buffer.
        w0 = writes_seen;
        for (int i = 0; i < 10; i++) begin
            push_byte(8'($urandom_range(0, 255)), waited);
        end
        wait_idle(200);
        chk("wrap_writes", writes_seen - w0, 10);
        chk("wrap_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sn76489_bus_writer.md
# sn76489_bus_writer

Bus-master front end for the TI SN76489 PSG core. Accepts command bytes from the sound-driver side over a valid/ready stream, buffers them in a small FIFO, and plays each onto the PSG write port (ti_D, ti_nWE, ti_nCE) using the chip's READY handshake. It also generates the PSG clock-enable pulse from CLK100MHZ, so it replaces the hand-driven switch interface and the free divider at top level.

## Interface
- CLK_DIV, 28, CLK100MHZ cycles per PSG tick (100 MHz / 28 ≈ 3.57 MHz); must be at least 2
- FIFO_DEPTH, 4, command buffer entries; power of two, at least 2
- READY_TIMEOUT, 64, maximum ticks spent in STROBE plus WAIT_RDY before the write is abandoned
- GAP_TICKS, 2, ticks with strobes deasserted between writes; must be at least 1

Reset is CPU_RESETN, asynchronous and active-low. The clock is CLK100MHZ.

- CLK100MHZ  in  1  system clock
- CPU_RESETN  in  1  async active-low reset
- in_data  in  8  PSG command byte
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO not full; a byte transfers when in_valid && in_ready
- ti_clk  out  1  one-cycle PSG tick pulse; drives ti_top CLK
- ti_D  out  8  PSG data bus
- ti_nWE  out  1  PSG write enable, active low
- ti_nCE  out  1  PSG chip enable, active low
- ti_READY  in  1  PSG READY; low while the chip is absorbing a write
- busy  out  1  state != IDLE or FIFO non-empty
- timeout_err  out  1  sticky flag, set when any write times out

## Operation
- **Tick generator**
  - Counter div runs 0..CLK_DIV-1 and wraps.
  - tick = (div == CLK_DIV-1); ti_clk is registered tick.
  - The first ti_clk pulse occurs CLK_DIV cycles after reset release.
- **READY synchronizer**
  - ti_READY is double-flopped in CLK100MHZ to give rdy_s.
  - The FSM samples rdy_s only on tick cycles.
- **FIFO**
  - Circular buffer with read pointer, write pointer and count (width log2(FIFO_DEPTH)+1). Pointers wrap modulo FIFO_DEPTH.
  - in_ready = (count != FIFO_DEPTH).
  - A pop occurs only in IDLE on a tick with count != 0.
  - Push and pop in the same cycle leaves count unchanged.
  - A byte pushed in the same cycle that IDLE evaluates an empty FIFO is not popped until the next tick.
- **FSM**: all transitions occur on tick cycles only.
  - IDLE: strobes high. If count != 0, pop into the D register and go to SETUP.
  - SETUP: ti_D = D, strobes high. Go to STROBE; clear the timeout counter.
  - STROBE: ti_nWE = ti_nCE = 0. If rdy_s = 0, go to WAIT_RDY.
  - WAIT_RDY: strobes low. If rdy_s = 1, go to RELEASE.
  - RELEASE: strobes high, ti_D held. Stay GAP_TICKS ticks, then go to IDLE.
- **Timeout**
  - The timeout counter increments each tick in STROBE or WAIT_RDY.
  - When it reaches READY_TIMEOUT: set timeout_err, go to RELEASE.
  - The byte is dropped, not retried.
- **Clearing timeout_err**: only reset clears it.
- **ti_D hold**: ti_D keeps its value from SETUP through the end of RELEASE and until the next SETUP.

## Timing
- **Reset values**
  - ti_nWE = ti_nCE = 1, ti_D = 0x00, ti_clk = 0, busy = 0, timeout_err = 0.
  - in_ready = 1, FIFO empty, state IDLE, div = 0.
- **Output registering**
  - All outputs except in_ready and busy are registered.
  - An FSM change on a tick cycle is visible on the next CLK100MHZ cycle, coincident with the ti_clk pulse.
- **Minimum write** (READY low at the first STROBE tick, high at the next): from the popping tick, 1 tick SETUP + 1 STROBE + 1 WAIT_RDY + GAP_TICKS RELEASE = 5 ticks = 140 cycles at defaults.
- **Push to pop latency**: push at cycle t makes count nonzero at t+1; the pop happens at the first tick at or after t+1 while in IDLE.
- **Reset mid-write**: strobes go high asynchronously, the FIFO is flushed and the in-flight byte is lost.

## Test plan
- **Reset:** hold CPU_RESETN low, then release. All reset values hold; ti_clk pulses one cycle wide exactly every 28 cycles, first pulse 28 cycles after release.
- **Single write:** push 0x8E. Use a PSG model that pulls READY low 1 tick after the strobe and holds it low for 3 ticks.
  - ti_D = 0x8E one tick before the strobes fall.
  - The strobes stay low until the first tick where synchronized READY is high.
  - Then 2 ticks high; busy falls on return to IDLE.
- **Burst:** push 0x8E, 0x0F, 0x90, 0x9F, 0xBF on consecutive cycles right after a tick.
  - in_ready drops after the 4th byte is accepted, and the 5th byte is held off until a pop.
  - Bytes appear on ti_D in order, each with a full strobe and gap.
- **Timeout:** hold READY high, then push 0x9F.
  - The strobe stays low exactly 64 ticks, timeout_err = 1, then RELEASE.
  - A following 0xBF completes normally and timeout_err stays 1.
- **Reset mid-strobe:** queue 3 bytes and assert reset while ti_nWE = 0.
  - The strobes go high asynchronously and count = 0.
  - After release, nothing is written until new pushes.
- **Wrap-around:** push 10 bytes while keeping the FIFO at most 4 deep. All 10 appear in order across pointer wraps, with no loss or duplication.
